// File: rtl/sequencer_pkg.sv
// rtl/sequencer_pkg.sv - shared encodings for the control sequencer
//   Instruction classes, ALU function selects, FSM state encoding,
//   instruction field positions, PC action codes and the control word type.
package sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_EXEC,
    ST_MEM,
    ST_HALT
  } state_t;

  // Decoder hint for where EXEC goes next.
  typedef enum logic [1:0] {
    NXT_FETCH,
    NXT_MEM,
    NXT_HALT
  } hint_t;

  localparam logic [3:0] CL_NOP  = 4'h0;
  localparam logic [3:0] CL_ADD  = 4'h1;
  localparam logic [3:0] CL_SUB  = 4'h2;
  localparam logic [3:0] CL_AND  = 4'h3;
  localparam logic [3:0] CL_OR   = 4'h4;
  localparam logic [3:0] CL_XOR  = 4'h5;
  localparam logic [3:0] CL_ADDI = 4'h6;
  localparam logic [3:0] CL_LD   = 4'h7;
  localparam logic [3:0] CL_ST   = 4'h8;
  localparam logic [3:0] CL_BZ   = 4'h9;
  localparam logic [3:0] CL_BN   = 4'hA;
  localparam logic [3:0] CL_BC   = 4'hB;
  localparam logic [3:0] CL_JMP  = 4'hC;
  localparam logic [3:0] CL_HALT = 4'hF;

  // FS_PASSA is zero so the idle control word and LD/ST/branch address
  // cycles present the same ALU function.
  localparam logic [4:0] FS_PASSA = 5'b00000;
  localparam logic [4:0] FS_ADD   = 5'b00010;
  localparam logic [4:0] FS_SUB   = 5'b00101;
  localparam logic [4:0] FS_AND   = 5'b01000;
  localparam logic [4:0] FS_OR    = 5'b01010;
  localparam logic [4:0] FS_XOR   = 5'b01100;

  localparam int CLASS_MSB = 15;
  localparam int CLASS_LSB = 12;
  localparam int DA_MSB    = 11;
  localparam int DA_LSB    = 9;
  localparam int AA_MSB    = 8;
  localparam int AA_LSB    = 6;
  localparam int BA_MSB    = 5;
  localparam int BA_LSB    = 3;
  localparam int IMM6_MSB  = 5;
  localparam int IMM12_MSB = 11;

  localparam logic [1:0] PS_HOLD   = 2'b00;
  localparam logic [1:0] PS_INC    = 2'b01;
  localparam logic [1:0] PS_BRANCH = 2'b10;

  typedef struct packed {
    logic [2:0]  aa;
    logic [2:0]  ba;
    logic [2:0]  da;
    logic [4:0]  fs;
    logic [15:0] k;
    logic        cin;
    logic        wr;
    logic        mw;
    logic        ma;
    logic        md;
  } ctrl_t;

  function automatic logic [15:0] sext6(input logic [5:0] v);
    return {{10{v[5]}}, v};
  endfunction

  function automatic logic [15:0] sext12(input logic [11:0] v);
    return {{4{v[11]}}, v};
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational IR + flags to control word decode
//   ir           : latched instruction
//   zero/neg     : datapath status, sampled during EXEC
//   carry        : stored carry flag
//   exec_ctrl    : control word for the EXEC cycle
//   mem_ctrl     : control word for the LD write-back cycle
//   branch_taken : PC takes pc + 1 + k at the end of EXEC
//   carry_load   : carry flag captures Cout at the end of EXEC
//   next_hint    : successor of EXEC
module instr_decoder
  import sequencer_pkg::*;
(
  input  logic [15:0] ir,
  input  logic        zero,
  input  logic        neg,
  input  logic        carry,
  output ctrl_t       exec_ctrl,
  output ctrl_t       mem_ctrl,
  output logic        branch_taken,
  output logic        carry_load,
  output hint_t       next_hint
);

  logic [3:0] cls;
  logic [2:0] da_f, aa_f, ba_f;

  assign cls  = ir[CLASS_MSB:CLASS_LSB];
  assign da_f = ir[DA_MSB:DA_LSB];
  assign aa_f = ir[AA_MSB:AA_LSB];
  assign ba_f = ir[BA_MSB:BA_LSB];

  always_comb begin
    exec_ctrl    = '0;
    mem_ctrl     = '0;
    branch_taken = 1'b0;
    carry_load   = 1'b0;
    next_hint    = NXT_FETCH;

    exec_ctrl.k = (cls == CL_JMP) ? sext12(ir[IMM12_MSB:0]) : sext6(ir[IMM6_MSB:0]);

    case (cls)
      CL_ADD, CL_SUB, CL_AND, CL_OR, CL_XOR: begin
        exec_ctrl.da = da_f;
        exec_ctrl.aa = aa_f;
        exec_ctrl.ba = ba_f;
        exec_ctrl.wr = 1'b1;
        case (cls)
          CL_ADD:  exec_ctrl.fs = FS_ADD;
          CL_SUB:  exec_ctrl.fs = FS_SUB;
          CL_AND:  exec_ctrl.fs = FS_AND;
          CL_OR:   exec_ctrl.fs = FS_OR;
          default: exec_ctrl.fs = FS_XOR;
        endcase
        exec_ctrl.cin = (cls == CL_SUB);
        carry_load    = (cls == CL_ADD) || (cls == CL_SUB);
      end
      CL_ADDI: begin
        // k occupies the A input, so the source register rides on B.
        exec_ctrl.da = da_f;
        exec_ctrl.ba = aa_f;
        exec_ctrl.ma = 1'b1;
        exec_ctrl.fs = FS_ADD;
        exec_ctrl.wr = 1'b1;
        carry_load   = 1'b1;
      end
      CL_LD: begin
        exec_ctrl.aa = aa_f;
        exec_ctrl.fs = FS_PASSA;
        // Address stays on the ALU while memory data is written back.
        mem_ctrl.aa  = aa_f;
        mem_ctrl.fs  = FS_PASSA;
        mem_ctrl.da  = da_f;
        mem_ctrl.md  = 1'b1;
        mem_ctrl.wr  = 1'b1;
        next_hint    = NXT_MEM;
      end
      CL_ST: begin
        exec_ctrl.aa = aa_f;
        exec_ctrl.ba = ba_f;
        exec_ctrl.fs = FS_PASSA;
        exec_ctrl.mw = 1'b1;
      end
      CL_BZ: begin
        exec_ctrl.aa = aa_f;
        exec_ctrl.fs = FS_PASSA;
        branch_taken = zero;
      end
      CL_BN: begin
        exec_ctrl.aa = aa_f;
        exec_ctrl.fs = FS_PASSA;
        branch_taken = neg;
      end
      CL_BC:   branch_taken = carry;
      CL_JMP:  branch_taken = 1'b1;
      CL_HALT: next_hint    = NXT_HALT;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fetch/load/exec sequencer for the 16-bit datapath
//   clock_50, clear    : clock, asynchronous active-low reset
//   run                : start from IDLE
//   instr              : instruction memory data, 1 cycle after pc
//   Cout, zero, neg    : datapath status
//   pc                 : instruction address
//   IR_L               : instruction register load strobe
//   AA/BA/DA/FS/k/Cin/WR/MW/MA/MD : datapath control word
//   PS                 : PC action (00 hold, 01 increment, 10 taken)
//   halted             : HALT reached
module control_sequencer
  import sequencer_pkg::*;
#(
  parameter int              PC_W   = 16,
  parameter logic [PC_W-1:0] RST_PC = '0
) (
  input  logic            clock_50,
  input  logic            clear,
  input  logic            run,
  input  logic [15:0]     instr,
  input  logic            Cout,
  input  logic            zero,
  input  logic            neg,
  output logic [PC_W-1:0] pc,
  output logic            IR_L,
  output logic [2:0]      AA,
  output logic [2:0]      BA,
  output logic [2:0]      DA,
  output logic [4:0]      FS,
  output logic [15:0]     k,
  output logic            Cin,
  output logic            WR,
  output logic            MW,
  output logic            MA,
  output logic            MD,
  output logic [1:0]      PS,
  output logic            halted
);

  state_t          state, state_nxt;
  logic [15:0]     ir;
  logic            carry;
  ctrl_t           exec_ctrl, mem_ctrl, ctrl;
  logic            branch_taken, carry_load;
  hint_t           next_hint;
  logic [PC_W-1:0] k_off;

  instr_decoder u_decoder (
    .ir           (ir),
    .zero         (zero),
    .neg          (neg),
    .carry        (carry),
    .exec_ctrl    (exec_ctrl),
    .mem_ctrl     (mem_ctrl),
    .branch_taken (branch_taken),
    .carry_load   (carry_load),
    .next_hint    (next_hint)
  );

  // Offset sign-extended (or truncated) to the PC width; sums wrap mod 2^PC_W.
  assign k_off = PC_W'($signed(exec_ctrl.k));

  always_ff @(posedge clock_50 or negedge clear) begin
    if (!clear) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clock_50 or negedge clear) begin
    if (!clear) begin
      pc    <= RST_PC;
      ir    <= '0;
      carry <= 1'b0;
    end else begin
      if (state == ST_LOAD) ir <= instr;
      if (state == ST_EXEC && carry_load) carry <= Cout;
      case (PS)
        PS_INC:    pc <= pc + PC_W'(1);
        PS_BRANCH: pc <= pc + PC_W'(1) + k_off;
        default:   ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    ctrl      = '0;
    PS        = PS_HOLD;
    IR_L      = 1'b0;
    halted    = 1'b0;
    case (state)
      ST_IDLE:  if (run) state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = ST_LOAD;
      ST_LOAD: begin
        IR_L      = 1'b1;
        state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        ctrl = exec_ctrl;
        case (next_hint)
          NXT_MEM:  state_nxt = ST_MEM;
          NXT_HALT: state_nxt = ST_HALT;
          default:  state_nxt = ST_FETCH;
        endcase
        if (next_hint == NXT_HALT) PS = PS_HOLD;
        else if (branch_taken)     PS = PS_BRANCH;
        else                       PS = PS_INC;
      end
      ST_MEM: begin
        ctrl      = mem_ctrl;
        state_nxt = ST_FETCH;
      end
      ST_HALT:  halted = 1'b1;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign AA  = ctrl.aa;
  assign BA  = ctrl.ba;
  assign DA  = ctrl.da;
  assign FS  = ctrl.fs;
  assign k   = ctrl.k;
  assign Cin = ctrl.cin;
  assign WR  = ctrl.wr;
  assign MW  = ctrl.mw;
  assign MA  = ctrl.ma;
  assign MD  = ctrl.md;

endmodule
